// File: rtl/keypad_guess_encoder.sv
// Scans and debounces a 4x3 keypad into a one-hot key code, holds the last digit and strobes push_0 on '#'.
// Optional macro KEY_AUTO_REPEAT_EN: periodic re-acceptance of a held digit.
module keypad_guess_encoder #(
  parameter int SCAN_DIV      = 1000,
  parameter int DEB_CYCLES    = 20000,
  parameter int PUSH_LEN      = 4,
  parameter int REPEAT_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row_n,
  output logic [2:0]  col_n,
  output logic [11:0] key,
  output logic [11:0] key_save,
  output logic        key_valid,
  output logic        push_0
);

  localparam int SCAN_W = $clog2(SCAN_DIV + 1);
  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int PUSH_W = $clog2(PUSH_LEN + 1);

  typedef enum logic [1:0] {SCAN, DEB_PRESS, PRESSED, DEB_REL} state_t;

  state_t              state;
  logic [1:0]          col;
  logic [1:0]          row_sel;
  logic [SCAN_W-1:0]   scan_cnt;
  logic [DEB_W-1:0]    deb_cnt;
  logic [PUSH_W-1:0]   push_cnt;

  logic [3:0]          row_low;
  logic                single_row;
  logic [1:0]          row_enc;
  logic [3:0]          held_pattern;
  logic [3:0]          key_idx;
  logic [11:0]         key_code;
  logic                is_star;
  logic                is_hash;
  logic                push_busy;
  logic [1:0]          col_next;

`ifdef KEY_AUTO_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  logic [REP_W-1:0]    rep_cnt;
`endif

  always_comb begin
    row_low      = ~row_n;
    single_row   = (row_low != 4'd0) && ((row_low & (row_low - 4'd1)) == 4'd0);
    row_enc      = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (row_low[i]) row_enc = 2'(i);
    end
    held_pattern = ~(4'b0001 << row_sel);
    key_idx      = ({2'b00, row_sel} * 4'd3) + {2'b00, col};
    key_code     = 12'd1 << key_idx;
    is_star      = (key_idx == 4'd9);
    is_hash      = (key_idx == 4'd11);
    // push_0 still low on its final cycle counts as busy
    push_busy    = (push_cnt != '0) || !push_0;
    col_next     = (col == 2'd2) ? 2'd0 : col + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      col       <= 2'd0;
      col_n     <= 3'b110;
      row_sel   <= 2'd0;
      scan_cnt  <= '0;
      deb_cnt   <= '0;
      push_cnt  <= '0;
      key       <= 12'd0;
      key_save  <= 12'd0;
      key_valid <= 1'b0;
      push_0    <= 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      key_valid <= 1'b0;

      // Submit strobe runs independently of the scan FSM
      if (push_cnt != '0) begin
        push_0   <= 1'b0;
        push_cnt <= push_cnt - PUSH_W'(1);
      end else begin
        push_0   <= 1'b1;
      end

      case (state)
        SCAN: begin
          if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            if (single_row) begin
              row_sel <= row_enc;
              deb_cnt <= '0;
              state   <= DEB_PRESS;
            end else begin
              col   <= col_next;
              col_n <= ~(3'b001 << col_next);
            end
          end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
          end
        end

        DEB_PRESS: begin
          if (row_n != held_pattern) begin
            state    <= SCAN;
            scan_cnt <= '0;
            col      <= col_next;
            col_n    <= ~(3'b001 << col_next);
          end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            state     <= PRESSED;
            key       <= key_code;
            key_valid <= 1'b1;
            if (is_star) begin
              key_save <= 12'd0;
            end else if (is_hash) begin
              if (key_save != 12'd0 && !push_busy) push_cnt <= PUSH_W'(PUSH_LEN);
            end else begin
              key_save <= key_code;
            end
`ifdef KEY_AUTO_REPEAT_EN
            rep_cnt <= '0;
`endif
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end

        PRESSED: begin
          if (row_n[row_sel]) begin
            deb_cnt <= '0;
            state   <= DEB_REL;
          end
`ifdef KEY_AUTO_REPEAT_EN
          else if (!is_star && !is_hash) begin
            if (rep_cnt == REP_W'(REPEAT_CYCLES - 1)) begin
              rep_cnt   <= '0;
              key_valid <= 1'b1;
              key_save  <= key_code;
            end else begin
              rep_cnt <= rep_cnt + REP_W'(1);
            end
          end
`endif
        end

        DEB_REL: begin
          if (!row_n[row_sel]) begin
            state <= PRESSED;
          end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            key      <= 12'd0;
            state    <= SCAN;
            scan_cnt <= '0;
            col      <= 2'd0;
            col_n    <= 3'b110;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

endmodule
